// File: rtl/flag_cond_pkg.sv
// Shared types and constants for the flag/condition unit: condition codes,
// FSM states, ALU opcode constants, flag bit positions and the flag-update decode.
package flag_cond_pkg;

  typedef enum logic [3:0] {
    COND_ALWAYS = 4'h0,
    COND_EQ     = 4'h1,
    COND_NE     = 4'h2,
    COND_MI     = 4'h3,
    COND_PL     = 4'h4,
    COND_CS     = 4'h5,
    COND_CC     = 4'h6,
    COND_VS     = 4'h7,
    COND_VC     = 4'h8,
    COND_LT     = 4'h9,
    COND_GE     = 4'hA,
    COND_LE     = 4'hB,
    COND_GT     = 4'hC,
    COND_HI     = 4'hD,
    COND_LS     = 4'hE,
    COND_NEVER  = 4'hF
  } cond_t;

  typedef enum logic {
    IDLE = 1'b0,
    EVAL = 1'b1
  } state_t;

  localparam logic [4:0] OP_SHL   = 5'b01000;
  localparam logic [4:0] OP_SHR   = 5'b01001;
  localparam logic [4:0] OP_ZERO  = 5'b10000;
  localparam logic [4:0] OP_PASSB = 5'b10011;
  localparam logic [4:0] OP_ONE   = 5'b11111;

  // Flag register layout is {O,C,S,Z}.
  localparam int FLAG_O = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_S = 1;
  localparam int FLAG_Z = 0;

  // Returns a per-flag write mask in {O,C,S,Z} order for a completing opcode.
  function automatic logic [3:0] flag_update_mask(input logic [4:0] op);
    logic [3:0] mask;
    mask = 4'b0000;
    if (op[4:3] == 2'b00) begin
      mask = 4'b1111;
    end else if (op == OP_SHL || op == OP_SHR) begin
      mask = 4'b0111;
    end else if (op == OP_ZERO) begin
      mask = 4'b0001;
    end else if (op == OP_PASSB || op == OP_ONE) begin
      mask = 4'b0000;
    end else if (op[4]) begin
      mask = 4'b0011;
    end
    return mask;
  endfunction

endpackage

// File: rtl/flag_cond_unit_cond_eval.sv
// Combinational branch-condition evaluator: flags {O,C,S,Z} plus a condition
// code produce the taken decision.
module cond_eval
  import flag_cond_pkg::*;
(
  input  logic [3:0] flags_i,
  input  cond_t      cond_i,
  output logic       taken_o
);

  logic f_o, f_c, f_s, f_z;
  logic lt;

  assign f_o = flags_i[FLAG_O];
  assign f_c = flags_i[FLAG_C];
  assign f_s = flags_i[FLAG_S];
  assign f_z = flags_i[FLAG_Z];
  // Signed less-than: sign differs from overflow.
  assign lt  = f_s ^ f_o;

  always_comb begin
    taken_o = 1'b0;
    case (cond_i)
      COND_ALWAYS: taken_o = 1'b1;
      COND_EQ:     taken_o = f_z;
      COND_NE:     taken_o = !f_z;
      COND_MI:     taken_o = f_s;
      COND_PL:     taken_o = !f_s;
      COND_CS:     taken_o = f_c;
      COND_CC:     taken_o = !f_c;
      COND_VS:     taken_o = f_o;
      COND_VC:     taken_o = !f_o;
      COND_LT:     taken_o = lt;
      COND_GE:     taken_o = !lt;
      COND_LE:     taken_o = lt | f_z;
      COND_GT:     taken_o = !(lt | f_z);
      COND_HI:     taken_o = f_c & !f_z;
      COND_LS:     taken_o = !f_c | f_z;
      COND_NEVER:  taken_o = 1'b0;
      default:     taken_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/flag_cond_unit.sv
// Architectural flag register with ALU-driven updates and a two-state branch
// condition evaluator. Optional flag shadow register under `FLAG_SHADOW_EN.
// Handshake: a request transfers on a cycle where BR_VALID && BR_READY are both
// high at the rising edge; the requester holds BR_VALID/BR_COND stable until then.
module flag_cond_unit
  import flag_cond_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       ALU_VALID,
  input  logic [4:0] ALU_OP,
  input  logic       O,
  input  logic       C,
  input  logic       S,
  input  logic       Z,
  input  logic       BR_VALID,
  input  logic [3:0] BR_COND,
  output logic       BR_READY,
  output logic       BR_DONE,
  output logic       BR_TAKEN,
  output logic [3:0] FLAGS,
`ifdef FLAG_SHADOW_EN
  input  logic       FLAG_SAVE,
  input  logic       FLAG_RESTORE,
`endif
  output state_t     dbg_state_o
);

  state_t     state_q, state_d;
  cond_t      cond_q, cond_d;
  logic [3:0] flags_q, flags_d;
  logic [3:0] alu_flags;
  logic [3:0] upd_mask;
  logic       accept;
  logic       cond_taken;

`ifdef FLAG_SHADOW_EN
  logic [3:0] shadow_q, shadow_d;
`endif

  assign alu_flags = {O, C, S, Z};
  assign upd_mask  = flag_update_mask(ALU_OP);

  // Stalling on ALU_VALID keeps an accepted request from racing a flag write.
  assign BR_READY = (state_q == IDLE) && !ALU_VALID && !reset;
  assign accept   = BR_VALID && BR_READY;

  always_comb begin
    flags_d = flags_q;
    if (ALU_VALID) begin
      flags_d = (flags_q & ~upd_mask) | (alu_flags & upd_mask);
    end
`ifdef FLAG_SHADOW_EN
    shadow_d = shadow_q;
    if (FLAG_RESTORE) begin
      flags_d = shadow_q;
    end else if (FLAG_SAVE) begin
      shadow_d = flags_q;
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    cond_d  = cond_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = EVAL;
          cond_d  = cond_t'(BR_COND);
        end
      end
      EVAL:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cond_q  <= COND_ALWAYS;
      flags_q <= 4'b0000;
    end else begin
      state_q <= state_d;
      cond_q  <= cond_d;
      flags_q <= flags_d;
    end
  end

`ifdef FLAG_SHADOW_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_q <= 4'b0000;
    end else begin
      shadow_q <= shadow_d;
    end
  end
`endif

  // Evaluates against the registered flags, so an ALU write in EVAL lands afterwards.
  cond_eval u_cond_eval (
    .flags_i (flags_q),
    .cond_i  (cond_q),
    .taken_o (cond_taken)
  );

  assign BR_DONE     = (state_q == EVAL) && !reset;
  assign BR_TAKEN    = BR_DONE && cond_taken;
  assign FLAGS       = flags_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_flag_cond_unit.sv
// Directed bench for flag_cond_unit: flag update rules, branch handshake,
// condition table, stall and reset behaviour (shadow tests with FLAG_SHADOW_EN).
module tb_flag_cond_unit;
  import flag_cond_pkg::*;

  logic       clk;
  logic       reset;
  logic       alu_valid;
  logic [4:0] alu_op;
  logic       o_in, c_in, s_in, z_in;
  logic       br_valid;
  logic [3:0] br_cond;
  logic       br_ready, br_done, br_taken;
  logic [3:0] flags;
  state_t     dbg_state;
`ifdef FLAG_SHADOW_EN
  logic       flag_save, flag_restore;
`endif

  int n_checks;
  int n_fail;

  flag_cond_unit dut (
    .clk          (clk),
    .reset        (reset),
    .ALU_VALID    (alu_valid),
    .ALU_OP       (alu_op),
    .O            (o_in),
    .C            (c_in),
    .S            (s_in),
    .Z            (z_in),
    .BR_VALID     (br_valid),
    .BR_COND      (br_cond),
    .BR_READY     (br_ready),
    .BR_DONE      (br_done),
    .BR_TAKEN     (br_taken),
    .FLAGS        (flags),
`ifdef FLAG_SHADOW_EN
    .FLAG_SAVE    (flag_save),
    .FLAG_RESTORE (flag_restore),
`endif
    .dbg_state_o  (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Driver tasks
  task automatic drive_alu(input logic v, input logic [4:0] op, input logic [3:0] ocsz);
    alu_valid = v;
    alu_op    = op;
    {o_in, c_in, s_in, z_in} = ocsz;
  endtask

  task automatic set_flags(input logic [3:0] ocsz);
    drive_alu(1'b1, 5'b00000, ocsz);
    step();
    drive_alu(1'b0, 5'b00000, 4'b0000);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive_alu(1'b1, 5'b00000, 4'b1111);
    br_valid = 1'b1;
    br_cond  = 4'h0;
    @(negedge clk);
    n_checks++;
    if (br_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got=%b exp=0", br_ready); end
    step();
    step();
    n_checks++;
    if (flags !== 4'b0000) begin n_fail++; $display("FAIL reset_flags got=%b exp=0000", flags); end
    n_checks++;
    if (br_done !== 1'b0 || br_taken !== 1'b0) begin
      n_fail++; $display("FAIL reset_done got=%b%b exp=00", br_done, br_taken);
    end
    n_checks++;
    if (dbg_state !== IDLE) begin n_fail++; $display("FAIL reset_state got=%0d exp=IDLE", dbg_state); end
    br_valid = 1'b0;
    drive_alu(1'b0, 5'b00000, 4'b0000);
    reset = 1'b0;
    step();
  endtask

  task automatic test_flag_update();
    logic [4:0] ops [7];
    logic [3:0] ins [7];
    logic [3:0] exps[7];
    ops[0] = 5'b00000; ins[0] = 4'b1101; exps[0] = 4'b1101;
    ops[1] = 5'b10110; ins[1] = 4'b0010; exps[1] = 4'b1110;
    ops[2] = OP_SHL;   ins[2] = 4'b0001; exps[2] = 4'b1001;
    ops[3] = OP_ZERO;  ins[3] = 4'b1110; exps[3] = 4'b1000;
    ops[4] = OP_PASSB; ins[4] = 4'b0111; exps[4] = 4'b1000;
    ops[5] = OP_ONE;   ins[5] = 4'b0111; exps[5] = 4'b1000;
    ops[6] = 5'b01010; ins[6] = 4'b0111; exps[6] = 4'b1000;
    for (int i = 0; i < 7; i++) begin
      drive_alu(1'b1, ops[i], ins[i]);
      step();
      n_checks++;
      if (flags !== exps[i]) begin
        n_fail++; $display("FAIL flag_update[%0d] op=%b got=%b exp=%b", i, ops[i], flags, exps[i]);
      end
    end
    drive_alu(1'b0, OP_SHR, 4'b0110);
    step();
    n_checks++;
    if (flags !== 4'b1000) begin n_fail++; $display("FAIL flag_hold got=%b exp=1000", flags); end
    drive_alu(1'b1, OP_SHR, 4'b0110);
    step();
    drive_alu(1'b0, 5'b00000, 4'b0000);
    n_checks++;
    if (flags !== 4'b1110) begin n_fail++; $display("FAIL flag_shr got=%b exp=1110", flags); end
  endtask

  task automatic test_branch();
    set_flags(4'b0001);
    br_valid = 1'b1;
    br_cond  = 4'h1;
    @(negedge clk);
    n_checks++;
    if (br_ready !== 1'b1) begin n_fail++; $display("FAIL br_ready_idle got=%b exp=1", br_ready); end
    n_checks++;
    if (br_done !== 1'b0) begin n_fail++; $display("FAIL br_done_early got=%b exp=0", br_done); end
    step();
    br_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (br_done !== 1'b1 || br_taken !== 1'b1) begin
      n_fail++; $display("FAIL br_eq_taken got=%b%b exp=11", br_done, br_taken);
    end
    n_checks++;
    if (br_ready !== 1'b0) begin n_fail++; $display("FAIL br_ready_eval got=%b exp=0", br_ready); end
    step();
    @(negedge clk);
    n_checks++;
    if (br_done !== 1'b0 || br_taken !== 1'b0) begin
      n_fail++; $display("FAIL br_done_pulse got=%b%b exp=00", br_done, br_taken);
    end
    step();
  endtask

  task automatic test_stall();
    set_flags(4'b0001);
    br_valid = 1'b1;
    br_cond  = 4'h1;
    drive_alu(1'b1, OP_ZERO, 4'b0000);
    @(negedge clk);
    n_checks++;
    if (br_ready !== 1'b0) begin n_fail++; $display("FAIL stall_ready got=%b exp=0", br_ready); end
    step();
    drive_alu(1'b0, 5'b00000, 4'b0000);
    n_checks++;
    if (dbg_state !== IDLE) begin n_fail++; $display("FAIL stall_consumed state=%0d exp=IDLE", dbg_state); end
    @(negedge clk);
    n_checks++;
    if (br_ready !== 1'b1 || br_done !== 1'b0) begin
      n_fail++; $display("FAIL stall_retry ready/done got=%b%b exp=10", br_ready, br_done);
    end
    step();
    br_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (br_done !== 1'b1 || br_taken !== 1'b0) begin
      n_fail++; $display("FAIL stall_eval got=%b%b exp=10", br_done, br_taken);
    end
    step();
  endtask

  task automatic test_cond_table();
    logic [3:0]  fl  [3];
    logic [15:0] tab [3];
    logic [15:0] exp_vec;
    fl[0] = 4'b1000; tab[0] = 16'b0100_1010_1101_0101;
    fl[1] = 4'b0110; tab[1] = 16'b0010_1011_0010_1101;
    fl[2] = 4'b0001; tab[2] = 16'b0100_1101_0101_0011;
    for (int f = 0; f < 3; f++) begin
      set_flags(fl[f]);
      exp_vec = tab[f];
      for (int k = 0; k < 16; k++) begin
        br_valid = 1'b1;
        br_cond  = 4'(k);
        step();
        br_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (br_done !== 1'b1 || br_taken !== exp_vec[k]) begin
          n_fail++;
          $display("FAIL cond flags=%b cond=%h done=%b taken=%b exp_taken=%b", fl[f], k, br_done, br_taken, exp_vec[k]);
        end
        step();
      end
    end
    drive_alu(1'b1, OP_PASSB, 4'b0111);
    step();
    drive_alu(1'b0, 5'b00000, 4'b0000);
    n_checks++;
    if (flags !== 4'b0001) begin n_fail++; $display("FAIL passb_hold got=%b exp=0001", flags); end
  endtask

  task automatic test_back_to_back();
    set_flags(4'b0000);
    br_valid = 1'b1;
    br_cond  = 4'h0;
    @(negedge clk);
    n_checks++;
    if (br_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready0 got=%b exp=1", br_ready); end
    step();
    @(negedge clk);
    n_checks++;
    if (br_done !== 1'b1 || br_taken !== 1'b1 || br_ready !== 1'b0) begin
      n_fail++; $display("FAIL b2b_first done/taken/ready got=%b%b%b exp=110", br_done, br_taken, br_ready);
    end
    step();
    br_cond = 4'hF;
    @(negedge clk);
    n_checks++;
    if (br_ready !== 1'b1 || br_done !== 1'b0) begin
      n_fail++; $display("FAIL b2b_gap ready/done got=%b%b exp=10", br_ready, br_done);
    end
    step();
    br_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (br_done !== 1'b1 || br_taken !== 1'b0) begin
      n_fail++; $display("FAIL b2b_second got=%b%b exp=10", br_done, br_taken);
    end
    step();
  endtask

  task automatic test_eval_alu();
    set_flags(4'b0001);
    br_valid = 1'b1;
    br_cond  = 4'h1;
    step();
    br_valid = 1'b0;
    drive_alu(1'b1, 5'b00000, 4'b0000);
    @(negedge clk);
    n_checks++;
    if (br_done !== 1'b1 || br_taken !== 1'b1) begin
      n_fail++; $display("FAIL eval_alu_taken got=%b%b exp=11", br_done, br_taken);
    end
    step();
    drive_alu(1'b0, 5'b00000, 4'b0000);
    n_checks++;
    if (flags !== 4'b0000) begin n_fail++; $display("FAIL eval_alu_flags got=%b exp=0000", flags); end
  endtask

  task automatic test_reset_in_eval();
    set_flags(4'b1111);
    br_valid = 1'b1;
    br_cond  = 4'h0;
    step();
    br_valid = 1'b0;
    reset    = 1'b1;
    @(negedge clk);
    n_checks++;
    if (br_done !== 1'b0 || br_taken !== 1'b0 || br_ready !== 1'b0) begin
      n_fail++; $display("FAIL rst_eval done/taken/ready got=%b%b%b exp=000", br_done, br_taken, br_ready);
    end
    step();
    reset = 1'b0;
    n_checks++;
    if (flags !== 4'b0000 || dbg_state !== IDLE) begin
      n_fail++; $display("FAIL rst_eval_after flags=%b state=%0d exp=0000/IDLE", flags, dbg_state);
    end
    @(negedge clk);
    n_checks++;
    if (br_done !== 1'b0) begin n_fail++; $display("FAIL rst_eval_late_done got=%b exp=0", br_done); end
    step();
  endtask

`ifdef FLAG_SHADOW_EN
  task automatic test_shadow();
    set_flags(4'b1010);
    flag_save = 1'b1;
    step();
    flag_save = 1'b0;
    set_flags(4'b0101);
    flag_restore = 1'b1;
    drive_alu(1'b1, 5'b00000, 4'b1111);
    step();
    flag_restore = 1'b0;
    drive_alu(1'b0, 5'b00000, 4'b0000);
    n_checks++;
    if (flags !== 4'b1010) begin n_fail++; $display("FAIL shadow_restore got=%b exp=1010", flags); end
    set_flags(4'b1111);
    flag_save    = 1'b1;
    flag_restore = 1'b1;
    step();
    flag_save    = 1'b0;
    flag_restore = 1'b0;
    n_checks++;
    if (flags !== 4'b1010) begin n_fail++; $display("FAIL shadow_both got=%b exp=1010", flags); end
    set_flags(4'b0000);
    flag_restore = 1'b1;
    step();
    flag_restore = 1'b0;
    n_checks++;
    if (flags !== 4'b1010) begin n_fail++; $display("FAIL shadow_no_save got=%b exp=1010", flags); end
  endtask
`endif

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    reset     = 1'b1;
    br_valid  = 1'b0;
    br_cond   = 4'h0;
    drive_alu(1'b0, 5'b00000, 4'b0000);
`ifdef FLAG_SHADOW_EN
    flag_save    = 1'b0;
    flag_restore = 1'b0;
`endif
    step();
    test_reset();
    test_flag_update();
    test_branch();
    test_stall();
    test_cond_table();
    test_back_to_back();
    test_eval_alu();
    test_reset_in_eval();
`ifdef FLAG_SHADOW_EN
    test_shadow();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/flag_cond_unit.md
FLAG_COND_UNIT -- requirements
Module: flag_cond_unit

Interface
REQ-001 Parameter: none; all widths fixed.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 ALU_VALID  input  1  ALU result and flags valid this cycle.
REQ-005 ALU_OP  input  5  opcode of the completing ALU operation.
REQ-006 O, C, S, Z  input  1 each  overflow, carry, sign and zero flags from the ALU.
REQ-007 BR_VALID  input  1  branch-condition request valid.
REQ-008 BR_COND  input  4  condition code to evaluate.
REQ-009 BR_READY  output  1  unit accepts a request this cycle.
REQ-010 BR_DONE  output  1  one-cycle pulse; BR_TAKEN is valid.
REQ-011 BR_TAKEN  output  1  evaluated condition result.
REQ-012 FLAGS  output  4  architectural flag register {O,C,S,Z}.

Function
REQ-013 On ALU_VALID, FLAGS SHALL update per ALU_OP:
- 00xxx: O, C, S and Z all update.
- 01000/01001: C, S and Z update; O holds.
- 10000: Z updates; O, C and S hold.
- 10011/11111: no flag updates.
- Other 1xxxx: S and Z update; O and C hold.
- Any other opcode: no flag updates.
REQ-014 A request is accepted on a cycle with BR_VALID && BR_READY; the unit SHALL latch BR_COND on acceptance.
REQ-015 FSM states: IDLE, EVAL.
- IDLE -> EVAL on acceptance; otherwise remain in IDLE.
- EVAL -> IDLE unconditionally.
REQ-016 BR_READY SHALL be 1 only when state==IDLE, !ALU_VALID and !reset. This stall prevents a same-cycle flag-update hazard.
REQ-017 In EVAL, the unit SHALL assert BR_DONE=1 and drive BR_TAKEN evaluated from the FLAGS register value at the start of that cycle. Latency is acceptance+1; throughput is one request per 2 cycles.
REQ-018 An ALU_VALID during EVAL SHALL update FLAGS at the end of that cycle without affecting the BR_TAKEN presented in that cycle.
REQ-019 Condition codes:
- 0: always.
- 1: Z. 2: !Z.
- 3: S. 4: !S.
- 5: C. 6: !C.
- 7: O. 8: !O.
- 9: S^O. A: !(S^O).
- B: (S^O)|Z. C: !((S^O)|Z).
- D: C&!Z. E: !C|Z.
- F: never.
REQ-020 Outside EVAL, BR_DONE SHALL be 0 and BR_TAKEN SHALL be 0.
REQ-021 A BR_VALID held while BR_READY=0 SHALL NOT be consumed; the requester holds BR_VALID and BR_COND stable.

Reset
REQ-022 While reset is high at a clock edge: FLAGS=4'b0000, state=IDLE, BR_DONE=0, BR_TAKEN=0.
REQ-023 BR_READY SHALL be 0 during any cycle with reset high.
REQ-024 Reset during EVAL SHALL abort the request with no BR_DONE pulse.
REQ-025 Reset SHALL take priority over a simultaneous ALU_VALID.

Configuration
REQ-026 Macro FLAG_SHADOW_EN adds ports FLAG_SAVE (in, 1) and FLAG_RESTORE (in, 1), plus a 4-bit shadow register reset to 0.
- FLAG_SAVE copies FLAGS into the shadow register.
- FLAG_RESTORE loads FLAGS from the shadow register, overriding ALU_VALID in the same cycle.
- If FLAG_SAVE and FLAG_RESTORE are both high, restore wins and no save occurs.
- Without FLAG_SHADOW_EN, neither port nor the shadow register exists.

Structure
REQ-027 Package flag_cond_pkg SHALL hold:
- cond_t enum (16 codes);
- state_t enum {IDLE, EVAL};
- opcode constants (OP_SHL=01000, OP_SHR=01001, OP_ZERO=10000, OP_PASSB=10011, OP_ONE=11111);
- flag bit indices.
REQ-028 Combinational sub-module cond_eval (FLAGS, cond -> taken) SHALL implement REQ-019; flag_cond_unit instantiates it once.

Verification
REQ-029 Reset, then ALU_VALID, OP=00000, O=1, C=1, S=0, Z=1 -> FLAGS=4'b1101 the next cycle.
REQ-030 FLAGS=1101, then ALU_VALID, OP=10110, S=1, Z=0 -> FLAGS=4'b1110 (O and C hold).
REQ-031 FLAGS=0001, BR_VALID, COND=1 with ALU_VALID=0 -> accepted; next cycle BR_DONE=1, BR_TAKEN=1.
REQ-032 BR_VALID and ALU_VALID (OP=10000, Z=0) in the same cycle -> BR_READY=0; the request is accepted the following cycle and COND=1 yields BR_TAKEN=0.
REQ-033 FLAGS={O=1,S=0,Z=0}, COND=9 -> BR_TAKEN=1. With COND=C -> BR_TAKEN=0. With ALU_OP=10011 and ALU_VALID -> FLAGS unchanged.
REQ-034 Reset asserted in EVAL -> no BR_DONE pulse; FLAGS=0. With FLAG_SHADOW_EN: save 1010, write 0101, then restore -> FLAGS=1010.
